// File: rtl/vdf_seq_pkg.sv
// Shared types and default sizing for the VDF squaring sequencer.
package vdf_seq_pkg;

  localparam int unsigned ITER_W_DEF     = 64;
  localparam int unsigned WDOG_W_DEF     = 16;
  localparam logic [15:0] WDOG_LIMIT_DEF = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT,
    ST_FLUSH,
    ST_DONE
  } seq_state_e;

endpackage

// File: rtl/vdf_seq_watchdog.sv
// Per-iteration watchdog: cleared on load, counts while enabled, flags expiry at LIMIT.
module vdf_seq_watchdog #(
  parameter int unsigned       WDOG_W = 16,
  parameter logic [WDOG_W-1:0] LIMIT  = '1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic enable,
  output logic expired
);

  logic [WDOG_W-1:0] cnt_q;
  logic [WDOG_W-1:0] cnt_d;

  // Load wins over counting; the count parks at LIMIT so it can never wrap back to zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = '0;
    end else if (enable && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + WDOG_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = enable && (cnt_q == LIMIT);

endmodule

// File: rtl/vdf_square_sequencer.sv
// Drives the modular squarer T times on a job seed and returns x0^(2^T) mod N,
// with abort, per-iteration watchdog and a squarer flush on any early exit.
module vdf_square_sequencer
  import vdf_seq_pkg::*;
#(
  parameter int unsigned       MOD_LEN    = 1024,
  parameter int unsigned       ITER_W     = ITER_W_DEF,
  parameter int unsigned       WDOG_W     = WDOG_W_DEF,
  parameter logic [WDOG_W-1:0] WDOG_LIMIT = WDOG_W'(WDOG_LIMIT_DEF)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               job_valid,
  output logic               job_ready,
  input  logic [MOD_LEN-1:0] job_x0,
  input  logic [ITER_W-1:0]  job_t,
  input  logic               abort,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [MOD_LEN-1:0] res_data,
  output logic               res_err,
  output logic [ITER_W-1:0]  iter_done,
  output logic               busy,
  output logic               sq_reset,
  output logic               sq_start,
  output logic [MOD_LEN-1:0] sq_in,
  input  logic [MOD_LEN-1:0] sq_out,
  input  logic               sq_valid
);

  seq_state_e         state_q, state_d;
  logic [ITER_W-1:0]  rem_q, rem_d;
  logic [ITER_W-1:0]  iter_done_q, iter_done_d;
  logic [MOD_LEN-1:0] sq_in_q, sq_in_d;
  logic [MOD_LEN-1:0] res_data_q, res_data_d;
  logic               res_valid_q, res_valid_d;
  logic               res_err_q, res_err_d;
  logic               sq_start_q, sq_start_d;
  logic               sq_reset_q, sq_reset_d;
  logic               flush_cnt_q, flush_cnt_d;
  logic               wdog_load;
  logic               wdog_en;
  logic               wdog_expired;

  vdf_seq_watchdog #(
    .WDOG_W (WDOG_W),
    .LIMIT  (WDOG_LIMIT)
  ) u_watchdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (wdog_load),
    .enable  (wdog_en),
    .expired (wdog_expired)
  );

  // Next-state and datapath decisions; abort beats a coincident result, a result beats a timeout.
  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    iter_done_d = iter_done_q;
    sq_in_d     = sq_in_q;
    res_data_d  = res_data_q;
    res_valid_d = res_valid_q;
    res_err_d   = res_err_q;
    sq_start_d  = 1'b0;
    sq_reset_d  = 1'b0;
    flush_cnt_d = flush_cnt_q;
    wdog_load   = 1'b0;
    wdog_en     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (job_valid) begin
          sq_in_d     = job_x0;
          rem_d       = job_t;
          iter_done_d = '0;
          if (job_t == '0) begin
            res_data_d  = job_x0;
            res_err_d   = 1'b0;
            res_valid_d = 1'b1;
            state_d     = ST_DONE;
          end else begin
            sq_start_d = 1'b1;
            state_d    = ST_LAUNCH;
          end
        end
      end
      ST_LAUNCH: begin
        wdog_load = 1'b1;
        if (abort) begin
          sq_reset_d  = 1'b1;
          flush_cnt_d = 1'b0;
          state_d     = ST_FLUSH;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        wdog_en = 1'b1;
        if (abort) begin
          sq_reset_d  = 1'b1;
          flush_cnt_d = 1'b0;
          state_d     = ST_FLUSH;
        end else if (sq_valid) begin
          iter_done_d = iter_done_q + ITER_W'(1);
          rem_d       = rem_q - ITER_W'(1);
          if (rem_q > ITER_W'(1)) begin
            sq_in_d    = sq_out;
            sq_start_d = 1'b1;
            state_d    = ST_LAUNCH;
          end else begin
            res_data_d  = sq_out;
            res_err_d   = 1'b0;
            res_valid_d = 1'b1;
            state_d     = ST_DONE;
          end
        end else if (wdog_expired) begin
          sq_reset_d  = 1'b1;
          flush_cnt_d = 1'b0;
          state_d     = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (flush_cnt_q) begin
          res_data_d  = sq_in_q;
          res_err_d   = 1'b1;
          res_valid_d = 1'b1;
          state_d     = ST_DONE;
        end else begin
          sq_reset_d  = 1'b1;
          flush_cnt_d = 1'b1;
        end
      end
      ST_DONE: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          res_err_d   = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM and registered outputs; sq_reset comes out of reset high so the squarer stays held one more cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rem_q       <= '0;
      iter_done_q <= '0;
      sq_in_q     <= '0;
      res_data_q  <= '0;
      res_valid_q <= 1'b0;
      res_err_q   <= 1'b0;
      sq_start_q  <= 1'b0;
      sq_reset_q  <= 1'b1;
      flush_cnt_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      iter_done_q <= iter_done_d;
      sq_in_q     <= sq_in_d;
      res_data_q  <= res_data_d;
      res_valid_q <= res_valid_d;
      res_err_q   <= res_err_d;
      sq_start_q  <= sq_start_d;
      sq_reset_q  <= sq_reset_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign job_ready = rst_n && (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_err   = res_err_q;
  assign iter_done = iter_done_q;
  assign sq_start  = sq_start_q;
  assign sq_reset  = sq_reset_q;
  assign sq_in     = sq_in_q;

endmodule

// File: tb/tb_vdf_square_sequencer.sv
// Self-checking bench: behavioural squarer (x^2 mod 65521, programmable latency)
// plus a repeated-squaring reference for expected results and timing.
module tb_vdf_square_sequencer;

  localparam int ML   = 16;
  localparam int IW   = 16;
  localparam int WDL  = 20;
  localparam longint PMOD = 65521;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          job_valid;
  logic          job_ready;
  logic [ML-1:0] job_x0;
  logic [IW-1:0] job_t;
  logic          abort;
  logic          res_valid;
  logic          res_ready;
  logic [ML-1:0] res_data;
  logic          res_err;
  logic [IW-1:0] iter_done;
  logic          busy;
  logic          sq_reset;
  logic          sq_start;
  logic [ML-1:0] sq_in;
  logic [ML-1:0] sq_out;
  logic          sq_valid;
  logic          model_valid;
  logic          stray_valid;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  int sq_lat     = 5;
  int sqrst_cnt  = 0;
  int start_cyc[$];
  int valid_cyc[$];
  int acc_cyc;

  bit      pend = 0;
  int      pend_cnt = 0;
  longint  pend_res = 0;

  assign sq_valid = model_valid | stray_valid;

  vdf_square_sequencer #(
    .MOD_LEN    (ML),
    .ITER_W     (IW),
    .WDOG_W     (16),
    .WDOG_LIMIT (16'd20)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .job_valid (job_valid),
    .job_ready (job_ready),
    .job_x0    (job_x0),
    .job_t     (job_t),
    .abort     (abort),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_err   (res_err),
    .iter_done (iter_done),
    .busy      (busy),
    .sq_reset  (sq_reset),
    .sq_start  (sq_start),
    .sq_in     (sq_in),
    .sq_out    (sq_out),
    .sq_valid  (sq_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural squarer: result appears sq_lat cycles after the launch cycle; sq_reset drops any pending work.
  always @(negedge clk) begin
    model_valid = 1'b0;
    if (sq_reset === 1'b1) begin
      pend = 0;
      sqrst_cnt++;
    end else begin
      if (pend) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          model_valid = 1'b1;
          sq_out      = ML'(pend_res);
          pend        = 0;
          valid_cyc.push_back(cyc);
        end
      end
      if (sq_start === 1'b1) begin
        pend     = 1;
        pend_cnt = sq_lat;
        pend_res = (longint'(sq_in) * longint'(sq_in)) % PMOD;
        start_cyc.push_back(cyc);
      end
    end
  end

  function automatic longint vdfRef(input longint x0, input int t);
    longint x = x0;
    for (int i = 0; i < t; i++) x = (x * x) % PMOD;
    return x;
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [ML-1:0] x0, input logic [IW-1:0] t);
    tick();
    start_cyc.delete();
    valid_cyc.delete();
    sqrst_cnt = 0;
    checkOutput("job_ready_idle", job_ready, 1);
    job_valid = 1'b1;
    job_x0    = x0;
    job_t     = t;
    acc_cyc   = cyc;
    @(posedge clk);
    #1;
    job_valid = 1'b0;
  endtask

  task automatic waitResult(output int rcyc);
    bit seen = 0;
    rcyc = -1;
    for (int k = 0; k < 400 && !seen; k++) begin
      tick();
      if (res_valid === 1'b1) begin
        seen = 1;
        rcyc = cyc;
      end
    end
    checkOutput("res_valid_arrives", seen, 1);
  endtask

  task automatic finishResult(input int hold, input logic [ML-1:0] exp_data, input logic [IW-1:0] exp_iter);
    for (int k = 0; k < hold; k++) begin
      abort       = (k == 3);
      stray_valid = (k == 5);
      tick();
      abort       = 1'b0;
      stray_valid = 1'b0;
      checkOutput("hold_res_valid", res_valid, 1);
      checkOutput("hold_res_data", res_data, exp_data);
      checkOutput("hold_iter_done", iter_done, exp_iter);
      checkOutput("hold_job_ready", job_ready, 0);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    checkOutput("post_hs_res_valid", res_valid, 0);
    checkOutput("post_hs_res_err", res_err, 0);
    checkOutput("post_hs_job_ready", job_ready, 1);
    checkOutput("post_hs_busy", busy, 0);
    checkOutput("post_hs_iter_hold", iter_done, exp_iter);
  endtask

  task automatic runJob(input string tag, input logic [ML-1:0] x0, input int t, input int lat, input int hold);
    int rcyc;
    logic [ML-1:0] exp_data;
    sq_lat    = lat;
    res_ready = (hold == 0);
    exp_data  = ML'(vdfRef(longint'(x0), t));
    applyStimulus(x0, IW'(t));
    waitResult(rcyc);
    $display("[TB] %s: x0=%0d T=%0d lat=%0d res=%0d", tag, x0, t, lat, res_data);
    checkOutput({tag, "_data"}, res_data, exp_data);
    checkOutput({tag, "_err"}, res_err, 0);
    checkOutput({tag, "_iter"}, iter_done, t);
    checkOutput({tag, "_busy"}, busy, 1);
    checkOutput({tag, "_nstart"}, start_cyc.size(), t);
    if (t == 0) begin
      checkOutput({tag, "_res_cyc"}, rcyc, acc_cyc + 1);
    end else if (start_cyc.size() == t && valid_cyc.size() == t) begin
      checkOutput({tag, "_first_start"}, start_cyc[0], acc_cyc + 1);
      checkOutput({tag, "_res_cyc"}, rcyc, valid_cyc[t-1] + 1);
      for (int i = 0; i < t; i++)
        checkOutput({tag, "_lat"}, valid_cyc[i], start_cyc[i] + lat);
      for (int i = 0; i + 1 < t; i++)
        checkOutput({tag, "_relaunch"}, start_cyc[i+1], valid_cyc[i] + 1);
    end
    finishResult(hold, exp_data, IW'(t));
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] global timeout");
  end

  initial begin
    int rcyc;
    int v2;
    bit got;
    logic [ML-1:0] x0r;

    rst_n = 1'b0; job_valid = 1'b0; job_x0 = '0; job_t = '0; abort = 1'b0;
    res_ready = 1'b0; stray_valid = 1'b0; model_valid = 1'b0; sq_out = '0;

    // Reset values
    repeat (3) tick();
    checkOutput("rst_job_ready", job_ready, 0);
    checkOutput("rst_sq_reset", sq_reset, 1);
    checkOutput("rst_res_valid", res_valid, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_sq_start", sq_start, 0);
    checkOutput("rst_sq_in", sq_in, 0);
    checkOutput("rst_res_data", res_data, 0);
    checkOutput("rst_iter_done", iter_done, 0);
    rst_n = 1'b1;
    #1;
    checkOutput("rel_sq_reset_hi", sq_reset, 1);
    checkOutput("rel_job_ready", job_ready, 1);
    tick();
    checkOutput("rel_sq_reset_lo", sq_reset, 0);

    // Directed jobs
    runJob("t3", 16'd3, 3, 5, 0);
    runJob("t0", 16'd7, 0, 5, 0);
    runJob("hold", 16'd3, 2, 5, 10);

    // Abort coincident with the second result
    sq_lat = 5;
    applyStimulus(16'd3, 16'd5);
    got = 0;
    v2  = -1;
    for (int k = 0; k < 100 && !got; k++) begin
      tick();
      if (valid_cyc.size() == 2) begin
        got = 1;
        v2  = cyc;
        abort = 1'b1;
      end
    end
    checkOutput("abort_second_valid_seen", got, 1);
    tick();
    abort = 1'b0;
    waitResult(rcyc);
    checkOutput("abort_data", res_data, 9);
    checkOutput("abort_err", res_err, 1);
    checkOutput("abort_iter", iter_done, 1);
    checkOutput("abort_sq_reset_cycles", sqrst_cnt, 2);
    checkOutput("abort_res_cyc", rcyc, v2 + 3);
    finishResult(1, 16'd9, 16'd1);

    // Watchdog timeout with a squarer slower than the limit
    x0r = ML'($urandom_range(65520, 2));
    sq_lat = 50;
    applyStimulus(x0r, 16'd3);
    waitResult(rcyc);
    checkOutput("wdog_data", res_data, x0r);
    checkOutput("wdog_err", res_err, 1);
    checkOutput("wdog_iter", iter_done, 0);
    checkOutput("wdog_sq_reset_cycles", sqrst_cnt, 2);
    checkOutput("wdog_no_result", valid_cyc.size(), 0);
    if (start_cyc.size() > 0) begin
      checkOutput("wdog_after_limit", (rcyc - start_cyc[0]) > WDL, 1);
      checkOutput("wdog_before_result", (rcyc - start_cyc[0]) < 50, 1);
    end
    finishResult(1, x0r, 16'd0);
    sq_lat = 5;

    // Asynchronous reset mid-WAIT, then a fresh job
    applyStimulus(16'd3, 16'd5);
    for (int k = 0; k < 100 && start_cyc.size() < 2; k++) tick();
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_job_ready", job_ready, 0);
    checkOutput("mid_rst_res_valid", res_valid, 0);
    checkOutput("mid_rst_res_err", res_err, 0);
    checkOutput("mid_rst_res_data", res_data, 0);
    checkOutput("mid_rst_iter_done", iter_done, 0);
    checkOutput("mid_rst_busy", busy, 0);
    checkOutput("mid_rst_sq_start", sq_start, 0);
    checkOutput("mid_rst_sq_in", sq_in, 0);
    checkOutput("mid_rst_sq_reset", sq_reset, 1);
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    checkOutput("mid_rel_sq_reset_hi", sq_reset, 1);
    tick();
    checkOutput("mid_rel_sq_reset_lo", sq_reset, 0);
    runJob("after_rst", 16'd2, 4, 5, 0);
    checkOutput("after_rst_is_15", vdfRef(2, 4), 15);

    // Randomized jobs
    for (int j = 0; j < 6; j++) begin
      runJob($sformatf("rnd%0d", j), ML'($urandom_range(65520, 2)),
             int'($urandom_range(6, 0)), int'($urandom_range(12, 1)),
             int'($urandom_range(3, 0)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
